// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage data-memory access sequencer (req/ack bus, stall,
//            aligned and extended load return). Optional ack timeout is
//            enabled with the MEM_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              we_mem,
    input  logic              re_mem,
    input  logic [2:0]        memdata_width,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] C_W  = 3'b010;
    localparam logic [2:0] C_H  = 3'b011;
    localparam logic [2:0] C_B  = 3'b100;
    localparam logic [2:0] C_HU = 3'b101;
    localparam logic [2:0] C_BU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state_q;
    logic [2:0] width_q;
    logic [1:0] lane_q;
    logic       load_q;

    logic        w_access;
    logic        w_is_w;
    logic        w_is_h;
    logic        w_is_b;
    logic        w_misalign;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;

    assign w_is_w     = (memdata_width == C_W);
    assign w_is_h     = (memdata_width == C_H) || (memdata_width == C_HU);
    assign w_is_b     = (memdata_width == C_B) || (memdata_width == C_BU);
    assign w_access   = req_valid & (we_mem | re_mem) & (w_is_w | w_is_h | w_is_b);
    assign w_misalign = (w_is_h & addr[0]) | (w_is_w & (addr[1:0] != 2'b00));

    // The response cycle releases the pipeline even though req_valid is still up.
    assign stall = ~rst & w_access & (state_q != S_RESP);

    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = 32'h0;
        if (we_mem) begin
            if (w_is_b) begin
                w_mask  = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end else if (w_is_h) begin
                w_mask  = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{wdata[15:0]}};
            end else begin
                w_mask  = 4'b1111;
                w_wdata = wdata;
            end
        end
    end

    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [2:0]  width,
                                            input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (width)
            C_W:     extract = word;
            C_H:     extract = {{16{h[15]}}, h};
            C_HU:    extract = {16'h0, h};
            C_B:     extract = {{24{b[7]}}, b};
            C_BU:    extract = {24'h0, b};
            default: extract = 32'h0;
        endcase
    endfunction

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            width_q    <= 3'b000;
            lane_q     <= 2'b00;
            load_q     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 4'b0000;
            resp_valid <= 1'b0;
            rdata      <= 32'h0;
            misalign   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_access) begin
                        width_q <= memdata_width;
                        lane_q  <= addr[1:0];
                        load_q  <= ~we_mem;
                        if (w_misalign) begin
                            misalign   <= 1'b1;
                            resp_valid <= 1'b1;
                            rdata      <= 32'h0;
                            state_q    <= S_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= we_mem;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wmask <= w_mask;
                            mem_wdata <= w_wdata;
`ifdef MEM_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                            state_q   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // Ack is checked first so a same-cycle ack beats expiry.
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wmask  <= 4'b0000;
                        rdata      <= load_q ? extract(mem_rdata, width_q, lane_q) : 32'h0;
                        resp_valid <= 1'b1;
                        state_q    <= S_RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wmask  <= 4'b0000;
                        rdata      <= 32'h0;
                        bus_err_q  <= 1'b1;
                        resp_valid <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    misalign   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    bus_err_q  <= 1'b0;
`endif
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed scoreboard bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        we_mem;
    logic        re_mem;
    logic [2:0]  memdata_width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
        logic        berr;
    } rsp_t;
    rsp_t sb_q[$];

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .we_mem(we_mem),
        .re_mem(re_mem), .memdata_width(memdata_width), .addr(addr),
        .wdata(wdata), .stall(stall), .resp_valid(resp_valid), .rdata(rdata),
        .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load extraction, written arithmetically.
    function automatic logic [31:0] model_load(input logic [31:0] word,
                                               input logic [2:0]  w,
                                               input logic [31:0] a);
        logic [31:0] v;
        logic [1:0]  lo;
        lo = a[1:0];
        case (w)
            3'b010: v = word;
            3'b011, 3'b101: begin
                v = (word >> (lo[1] ? 16 : 0)) & 32'h0000FFFF;
                if (w == 3'b011 && v[15]) v = v | 32'hFFFF0000;
            end
            3'b100, 3'b110: begin
                v = (word >> (8 * lo)) & 32'h000000FF;
                if (w == 3'b100 && v[7]) v = v | 32'hFFFFFF00;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Drives one access and follows it until its response (or a cycle budget).
    // dly = BUSY cycle index on which ack is returned (large => never).
    task automatic run_acc(input string tag, input logic we, input logic re,
                           input logic [2:0] w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rword,
                           input int dly, input logic chg,
                           input logic [31:0] e_rd, input logic e_mis,
                           input logic e_berr, input logic [3:0] e_mask,
                           input logic [31:0] e_wd, input int e_lat);
        int   cyc;
        int   busy;
        int   stalls;
        bit   done;
        rsp_t r;
        req_valid = 1'b1; we_mem = we; re_mem = re; memdata_width = w;
        addr = a; wdata = wd; mem_ack = 1'b0;
        sb_q.push_back('{rd: e_rd, mis: e_mis, berr: e_berr});
        cyc = 0; busy = 0; stalls = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            #4;
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk({tag, "_unexpected_resp"}, 32'd1, 32'd0);
                end else begin
                    r = sb_q.pop_front();
                    chk({tag, "_rdata"}, rdata, r.rd);
                    chk({tag, "_misalign"}, {31'b0, misalign}, {31'b0, r.mis});
                    chk({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, r.berr});
                end
                chk({tag, "_resp_stall"}, {31'b0, stall}, 32'd0);
                chk({tag, "_latency"}, cyc, e_lat);
                chk({tag, "_stall_cycles"}, stalls, e_lat);
                if (e_mis) chk({tag, "_mis_noreq"}, busy, 32'd0);
                else       chk({tag, "_req_cycles"}, busy, e_lat - 1);
                done = 1'b1;
            end else begin
                if (stall) stalls++;
                if (mem_req) begin
                    if (busy == 0 || busy == dly) begin
                        chk({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
                        chk({tag, "_mem_wmask"}, {28'b0, mem_wmask}, {28'b0, e_mask});
                        chk({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, we});
                        if (we) chk({tag, "_mem_wdata"}, mem_wdata, e_wd);
                    end
                    if (busy == dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rword;
                    end
                    busy++;
                end
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (chg && busy == 2) begin
                addr  = a + 32'd4;
                wdata = ~wd;
            end
            cyc++;
        end
        if (!done) chk({tag, "_resp_timeout"}, 32'd1, 32'd0);
        req_valid = 1'b0; we_mem = 1'b0; re_mem = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b1; we_mem = 1'b0; re_mem = 1'b1; memdata_width = 3'b010;
        addr = 32'h104; wdata = 32'h0; mem_ack = 1'b1; mem_rdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #4;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;

        // Non-access width: no stall, no bus request.
        req_valid = 1'b1; re_mem = 1'b1; memdata_width = 3'b001;
        #4 chk("none_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #4;
        chk("none_mem_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; re_mem = 1'b0;

        run_acc("lw", 0, 1, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0,
                model_load(32'hDEADBEEF, 3'b010, 32'h104), 0, 0, 4'b0000, 32'h0, 2);
        run_acc("sb", 1, 0, 3'b100, 32'h203, 32'h000000A5, 32'hFFFFFFFF, 1, 0,
                32'h0, 0, 0, 4'b1000, 32'hA5A5A5A5, 3);
        run_acc("lb", 0, 1, 3'b100, 32'h12, 32'h0, 32'h00F10000, 0, 0,
                model_load(32'h00F10000, 3'b100, 32'h12), 0, 0, 4'b0000, 32'h0, 2);
        run_acc("lbu", 0, 1, 3'b110, 32'h12, 32'h0, 32'h00F10000, 0, 0,
                model_load(32'h00F10000, 3'b110, 32'h12), 0, 0, 4'b0000, 32'h0, 2);
        run_acc("lh", 0, 1, 3'b011, 32'h12, 32'h0, 32'h00F10000, 0, 0,
                model_load(32'h00F10000, 3'b011, 32'h12), 0, 0, 4'b0000, 32'h0, 2);
        run_acc("lh_neg", 0, 1, 3'b011, 32'h20, 32'h0, 32'h1234_8001, 2, 0,
                model_load(32'h12348001, 3'b011, 32'h20), 0, 0, 4'b0000, 32'h0, 4);
        run_acc("lhu", 0, 1, 3'b101, 32'h22, 32'h0, 32'h9876_0001, 0, 0,
                model_load(32'h98760001, 3'b101, 32'h22), 0, 0, 4'b0000, 32'h0, 2);
        run_acc("sh", 1, 0, 3'b011, 32'h2, 32'h0000BEEF, 32'h0, 0, 0,
                32'h0, 0, 0, 4'b1100, 32'hBEEFBEEF, 2);
        run_acc("sbu_both", 1, 1, 3'b110, 32'h1, 32'h0000003C, 32'h0, 0, 0,
                32'h0, 0, 0, 4'b0010, 32'h3C3C3C3C, 2);
        run_acc("sw_mis", 1, 0, 3'b010, 32'h6, 32'h11111111, 32'h0, 99, 0,
                32'h0, 1, 0, 4'b0000, 32'h0, 1);
        run_acc("lh_mis", 0, 1, 3'b011, 32'h5, 32'h0, 32'h0, 99, 0,
                32'h0, 1, 0, 4'b0000, 32'h0, 1);
        run_acc("sw_slow", 1, 0, 3'b010, 32'h40, 32'h12345678, 32'h0, 5, 1,
                32'h0, 0, 0, 4'b1111, 32'h12345678, 7);
        run_acc("lbu_hold", 0, 1, 3'b110, 32'h33, 32'h0, 32'hC3000000, 0, 0,
                model_load(32'hC3000000, 3'b110, 32'h33), 0, 0, 4'b0000, 32'h0, 2);

        // Async reset in the middle of BUSY; rdata currently holds 0xC3.
        req_valid = 1'b1; re_mem = 1'b1; memdata_width = 3'b010; addr = 32'h104;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstbusy_req_before", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstbusy_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstbusy_stall", {31'b0, stall}, 32'd0);
        chk("rstbusy_rdata", rdata, 32'd0);
        chk("rstbusy_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; re_mem = 1'b0;
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        run_acc("lw_timeout", 0, 1, 3'b010, 32'h80, 32'h0, 32'h0, 99, 0,
                32'h0, 0, 1, 4'b0000, 32'h0, TO + 1);
        run_acc("lw_ack_expiry", 0, 1, 3'b010, 32'h84, 32'h0, 32'hCAFEF00D, TO - 1, 0,
                32'hCAFEF00D, 0, 0, 4'b0000, 32'h0, TO + 1);
`endif

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
